// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read, dual-write register file with per-register busy bits
// Optional macro RF_BYPASS_EN forwards same-cycle write data (and busy) to the read ports.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         wen1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic                         set_en,
  input  logic [ADDR_WIDTH-1:0]        set_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic set_ok;

  assign wr0_ok = wen0 && (waddr0 != '0);
  assign wr1_ok = wen1 && (waddr1 != '0);
  assign set_ok = set_en && (set_addr != '0);

  // Port 1 is applied after port 0 so it wins on a collision; set is applied last so it wins over clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      mem_d[waddr0]  = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (wr1_ok) begin
      mem_d[waddr1]  = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (set_ok) begin
      busy_d[set_addr] = 1'b1;
    end
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = mem_q[ra];
      rb = busy_q[ra];
`ifdef RF_BYPASS_EN
      if (wr0_ok && (waddr0 == ra)) begin
        rd = wdata0;
        rb = set_ok && (set_addr == ra);
      end
      if (wr1_ok && (waddr1 == ra)) begin
        rd = wdata1;
        rb = set_ok && (set_addr == ra);
      end
`endif
      // Forwarded data must not leak out while reset holds the array cleared.
      if (rst) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[k]                          = rb;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed plus randomized checks of reg_file_mp against an array model
// Expectations follow RF_BYPASS_EN when the bundle is built with that macro.
module tb_reg_file_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           wen0, wen1, set_en;
  logic [AW-1:0]  waddr0, waddr1, set_addr;
  logic [DW-1:0]  wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem  [DEPTH];
  logic          ref_busy [DEPTH];

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_RD    (NR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wen0    (wen0),
    .waddr0  (waddr0),
    .wdata0  (wdata0),
    .wen1    (wen1),
    .waddr1  (waddr1),
    .wdata1  (wdata1),
    .set_en  (set_en),
    .set_addr(set_addr),
    .raddr   (raddr),
    .rdata   (rdata),
    .rbusy   (rbusy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      ref_busy[i] = 1'b0;
    end
  endtask

  // Register 0 is never touched; later writes overwrite earlier ones; a set beats a clear.
  task automatic ref_edge();
    if (!rst) begin
      if (wen0 && waddr0 != 0) begin ref_mem[waddr0] = wdata0; ref_busy[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 0) begin ref_mem[waddr1] = wdata1; ref_busy[waddr1] = 1'b0; end
      if (set_en && set_addr != 0) ref_busy[set_addr] = 1'b1;
    end
  endtask

  task automatic check_reads(input string tag);
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      logic          eb;
      a  = raddr[k*AW +: AW];
      ed = rst ? '0 : ref_mem[a];
      eb = rst ? 1'b0 : ref_busy[a];
`ifdef RF_BYPASS_EN
      if (!rst && a != 0 && ((wen0 && waddr0 == a) || (wen1 && waddr1 == a))) begin
        ed = (wen1 && waddr1 == a) ? wdata1 : wdata0;
        eb = set_en && (set_addr == a);
      end
`endif
      chk($sformatf("%s.rdata%0d", tag, k), rdata[k*DW +: DW], ed);
      chk($sformatf("%s.rbusy%0d", tag, k), {31'b0, rbusy[k]}, {31'b0, eb});
    end
  endtask

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0; set_en = 1'b0;
  endtask

  task automatic set_raddr(input int a0, input int a1, input int a2);
    raddr[0*AW +: AW] = AW'(a0);
    raddr[1*AW +: AW] = AW'(a1);
    raddr[2*AW +: AW] = AW'(a2);
  endtask

  task automatic tick(input string tag);
    #1;
    check_reads(tag);
    @(posedge clk);
    ref_edge();
    #1;
    idle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    waddr0 = '0; waddr1 = '0; set_addr = '0;
    wdata0 = '0; wdata1 = '0;
    set_raddr(3, 0, 7);
    ref_clear();

    // Reset state, including writes and sets that must be ignored while rst is high.
    tick("rst_idle");
    wen0 = 1'b1; waddr0 = 3; wdata0 = 32'h1111_2222;
    set_en = 1'b1; set_addr = 7;
    tick("rst_wr_ignored");
    set_raddr(3, 3, 7);
    #1;
    check_reads("rst_after");
    chk("rst_reg3", rdata[0 +: DW], 32'h0);
    chk("rst_busy7", {31'b0, rbusy[2]}, 32'h0);
    rst = 1'b0;

    // Asynchronous reset wipes reg3 without a clock edge.
    wen0 = 1'b1; waddr0 = 3; wdata0 = 32'hDEAD_BEEF;
    tick("w3");
    chk("reg3_written", rdata[0 +: DW], 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    ref_clear();
    chk("async_rst_reg3", rdata[0 +: DW], 32'h0);
    check_reads("async_rst");
    rst = 1'b0;

    // Reset held across an edge defeats a write; the next edge accepts writes.
    wen0 = 1'b1; waddr0 = 6; wdata0 = 32'h0000_1234;
    set_raddr(6, 6, 6);
    rst = 1'b1;
    tick("rst_wr");
    rst = 1'b0;
    #1;
    chk("rst_wins_reg6", rdata[0 +: DW], 32'h0);
    wen0 = 1'b1; waddr0 = 6; wdata0 = 32'h0000_0077;
    tick("wr_after_rst");
    chk("first_edge_reg6", rdata[0 +: DW], 32'h77);

    // Register 0 ignores writes and sets.
    wen0 = 1'b1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    set_en = 1'b1; set_addr = 0;
    tick("w0");
    set_raddr(0, 0, 0);
    #1;
    chk("reg0_data", rdata[0 +: DW], 32'h0);
    chk("reg0_busy", {31'b0, rbusy[0]}, 32'h0);

    // Dual write to the same register: port 1 wins, all read ports agree.
    wen0 = 1'b1; waddr0 = 5; wdata0 = 32'h11;
    wen1 = 1'b1; waddr1 = 5; wdata1 = 32'h22;
    tick("dual5");
    set_raddr(5, 5, 5);
    #1;
    chk("dual5_p0", rdata[0*DW +: DW], 32'h22);
    chk("dual5_p1", rdata[1*DW +: DW], 32'h22);
    chk("dual5_p2", rdata[2*DW +: DW], 32'h22);

    // Busy set on reg7, cleared by a port-1 write two cycles later.
    set_en = 1'b1; set_addr = 7;
    set_raddr(7, 7, 7);
    tick("set7");
    chk("busy7_c1", {31'b0, rbusy[2]}, 32'h1);
    tick("hold7");
    chk("busy7_c2", {31'b0, rbusy[2]}, 32'h1);
    wen1 = 1'b1; waddr1 = 7; wdata1 = 32'h55;
    tick("w7");
    chk("busy7_clr", {31'b0, rbusy[2]}, 32'h0);
    chk("data7", rdata[2*DW +: DW], 32'h55);

    // Set and write on the same register: data lands, busy stays set.
    set_en = 1'b1; set_addr = 9;
    wen0 = 1'b1; waddr0 = 9; wdata0 = 32'hCAFE;
    tick("setwr9");
    set_raddr(9, 9, 9);
    #1;
    chk("setwr9_data", rdata[0 +: DW], 32'hCAFE);
    chk("setwr9_busy", {31'b0, rbusy[1]}, 32'h1);

    // Same-cycle read of a register being written.
    wen0 = 1'b1; waddr0 = 4; wdata0 = 32'h3C;
    tick("w4_old");
    wen0 = 1'b1; waddr0 = 4; wdata0 = 32'hA5;
    set_raddr(0, 4, 9);
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass4", rdata[1*DW +: DW], 32'hA5);
`else
    chk("bypass4", rdata[1*DW +: DW], 32'h3C);
`endif
    tick("w4_new");
    chk("reg4_after", rdata[1*DW +: DW], 32'hA5);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      wen0     = 1'($urandom_range(0, 1));
      waddr0   = AW'($urandom_range(0, 9));
      wdata0   = $urandom;
      wen1     = 1'($urandom_range(0, 1));
      waddr1   = AW'($urandom_range(0, 9));
      wdata1   = $urandom;
      set_en   = ($urandom_range(0, 3) == 0);
      set_addr = AW'($urandom_range(0, 9));
      for (int k = 0; k < NR; k++) begin
        raddr[k*AW +: AW] = ($urandom_range(0, 15) == 0) ? AW'(31) : AW'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        ref_clear();
        check_reads("rnd_rst");
        rst = 1'b0;
      end
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: register width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5: address width; depth is 2**ADDR_WIDTH registers.
REQ-003 The block SHALL have parameter NUM_RD, default 2: number of read ports, legal range 1..8.
REQ-004 The block SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 The block SHALL have ports wen0 / waddr0 / wdata0, input, 1 / ADDR_WIDTH / DATA_WIDTH: write port 0.
REQ-007 The block SHALL have ports wen1 / waddr1 / wdata1, input, 1 / ADDR_WIDTH / DATA_WIDTH: write port 1.
REQ-008 The block SHALL have ports set_en / set_addr, input, 1 / ADDR_WIDTH: mark a register busy (pending producer).
REQ-009 The block SHALL have port raddr, input, NUM_RD*ADDR_WIDTH: read addresses, with port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 The block SHALL have port rdata, output, NUM_RD*DATA_WIDTH: read data, with port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The block SHALL have port rbusy, output, NUM_RD: busy flag of each read port's address.

Function
REQ-012 Storage SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits plus one busy bit per register.
REQ-013 Register 0 SHALL be hardwired: reads return 0, writes and set_en targeting it are ignored, and its busy bit SHALL read 0.
REQ-014 Reads SHALL be combinational with zero latency: rdata[k] = reg[raddr[k]] and rbusy[k] = busy[raddr[k]].
REQ-015 On a rising clk edge, if wen0=1 and waddr0!=0, reg[waddr0] SHALL be updated to wdata0; the same rule SHALL apply to port 1.
REQ-016 If both write ports are enabled to the same nonzero address, port 1 SHALL win and wdata0 SHALL be discarded.
REQ-017 A write on either port SHALL clear busy[waddr] at that edge.
REQ-018 set_en=1 SHALL set busy[set_addr] at the edge.
REQ-019 If set and write hit the same address in the same cycle, set SHALL win: data is written and busy ends at 1.
REQ-020 Write port enables SHALL be independent, with no handshake; a write to a register that is not busy SHALL still be legal and SHALL leave its busy bit at 0.
REQ-021 Multiple read ports addressing the same register SHALL return identical values.

Reset
REQ-022 rst=1 SHALL asynchronously clear all registers to 0 and all busy bits to 0, with no clock edge needed.
REQ-023 While rst=1, writes and sets SHALL be ignored; rdata SHALL read all-zeros and rbusy SHALL read all-zeros.
REQ-024 A reset asserted in the same cycle as a write SHALL win; the write SHALL be lost.
REQ-025 After rst deasserts, the first rising edge SHALL accept writes normally.

Configuration
REQ-026 With macro RF_BYPASS_EN defined, a read address matching an enabled same-cycle write (nonzero address) SHALL return that write's wdata combinationally, following the REQ-016 priority.
REQ-027 With RF_BYPASS_EN defined, in that same bypass case rbusy SHALL read 0, unless set_en targets the same address.
REQ-028 Without RF_BYPASS_EN, reads SHALL return the pre-edge stored value and stored busy bit, and no forwarding logic SHALL be present.

Verification
REQ-029 The bench SHALL cover: rst pulse mid-cycle after writing reg3=0xDEADBEEF -> rdata for reg3 reads 0 immediately, without a clock edge.
REQ-030 The bench SHALL cover: wen0 with waddr0=0 and wdata0=0xFFFFFFFF, then read address 0 -> rdata 0 and rbusy 0.
REQ-031 The bench SHALL cover: wen0 and wen1 both to reg5 with 0x11 and 0x22 -> next cycle, all read ports on reg5 return 0x22.
REQ-032 The bench SHALL cover: set_en reg7, then wen1 reg7=0x55 two cycles later -> rbusy on reg7 is 1 for 2 cycles, then 0 with data 0x55.
REQ-033 The bench SHALL cover: set_en and wen0 on reg9 in the same cycle -> reg9 holds wdata0 and busy is 1.
REQ-034 The bench SHALL cover: with RF_BYPASS_EN, wen0 reg4=0xA5 while raddr port 1 = 4 -> rdata port 1 reads 0xA5 in that same cycle; without the macro it reads the old value.
